// File: rtl/mem_dma.sv
// Byte-wide block-transfer engine: copies a source range to a destination
// range, or fills a destination range with a constant, over a single-port memory.
module mem_dma #(
  parameter int unsigned addr_width = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [addr_width-1:0] src,
  input  logic [addr_width-1:0] dst,
  input  logic [addr_width-1:0] len,
  input  logic [7:0]            fill_byte,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] count,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [addr_width-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [addr_width-1:0] ptr_one = addr_width'(1);

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [addr_width-1:0] src_ptr_q, src_ptr_d;
  logic [addr_width-1:0] dst_ptr_q, dst_ptr_d;
  logic [addr_width-1:0] rem_q, rem_d;
  logic [addr_width-1:0] count_q, count_d;
  logic [7:0]            data_q, data_d;

  // NOTE: every register takes <= so all flops update together from the
  // pre-edge values; the asynchronous reset clears the whole datapath too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      data_q    <= data_d;
    end
  end

  // NOTE: each _d starts as a copy of its _q, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    count_d   = count_q;
    data_d    = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          src_ptr_d = src;
          dst_ptr_d = dst;
          rem_d     = len;
          count_d   = '0;
          if (mode) data_d = fill_byte;
          if (len == '0)  state_d = S_DONE;
          else if (mode)  state_d = S_WRITE;
          else            state_d = S_READ;
        end
      end
      S_READ: begin
        data_d    = mem_rdata;
        src_ptr_d = src_ptr_q + ptr_one;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        dst_ptr_d = dst_ptr_q + ptr_one;
        count_d   = count_q + ptr_one;
        rem_d     = rem_q - ptr_one;
        // Each read follows the previous write, so overlapping copies replicate.
        if (rem_q == ptr_one) state_d = S_DONE;
        else if (mode_q)      state_d = S_WRITE;
        else                  state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs decode only from registered state and pointers.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: ;
      S_READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = src_ptr_q;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = dst_ptr_q;
        mem_wdata = data_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed self-checking bench for mem_dma with a 64 KiB byte memory model.
module tb_mem_dma;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [15:0] src, dst, len;
  logic [7:0]  fill_byte;
  logic        busy, done;
  logic [15:0] count;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];

  mem_dma #(.addr_width(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_byte (fill_byte),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr]  <= pl_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // Bus protocol monitor, active for the whole run.
  always @(negedge clk) begin
    n_cmp++;
    if (mem_read && mem_write) begin
      n_bad++;
      $display("FAIL proto_rw_both: mem_read=%0b mem_write=%0b, required not both 1", mem_read, mem_write);
    end
    n_cmp++;
    if (!mem_read && !mem_write && (mem_addr !== 16'h0 || mem_wdata !== 8'h0)) begin
      n_bad++;
      $display("FAIL proto_idle_bus: mem_addr=%h mem_wdata=%h, required 0000/00", mem_addr, mem_wdata);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issues one command from a negedge and observes cycles 1.. after the accepting edge.
  // Returns at the negedge of the first cycle with busy low.
  task automatic run_cmd(input logic m, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [7:0] f, input int restart_at,
                         output int done_cyc, output int done_pulses, output int rd_n,
                         output int wr_n, output int idle_cyc);
    wa_q.delete();
    wd_q.delete();
    done_cyc = 0; done_pulses = 0; rd_n = 0; wr_n = 0; idle_cyc = 0;
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_byte = f;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        mode = 1'b1; src = 16'h0010; dst = 16'h0300; len = 16'd5; fill_byte = 8'hCC;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (mem_read) rd_n++;
      if (mem_write) begin
        wr_n++;
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
      end
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (idle_cyc == 0) begin
      n_bad++;
      $display("FAIL cmd_timeout: busy still high after 200 cycles, required to finish");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_byte = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, count, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b count=%h rd=%b wr=%b addr=%h wdata=%h, required all 0",
               busy, done, count, mem_read, mem_write, mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      poke(16'h0010 + 16'(i), 8'h11 * 8'(i + 1));
      poke(16'h0080 + 16'(i), 8'h00);
      poke(16'h0090 + 16'(i), 8'h00);
      poke(16'h0040 + 16'(i), (i == 0) ? 8'h07 : 8'(i));
      poke(16'hFFFE + 16'(i), 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      poke(16'h0050 + 16'(i), 8'h61 + 8'(i));
      poke(16'h00A0 + 16'(i), 8'hEE);
    end
    poke(16'h0300, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_copy();
    int dc, dp, rd, wr, ic;
    run_cmd(1'b0, 16'h0010, 16'h0080, 16'd4, 8'h00, 0, dc, dp, rd, wr, ic);
    n_cmp++; if (dc !== 9)  begin n_bad++; $display("FAIL copy_done_cycle: got %0d, required 9", dc); end
    n_cmp++; if (dp !== 1)  begin n_bad++; $display("FAIL copy_done_pulses: got %0d, required 1", dp); end
    n_cmp++; if (ic !== 10) begin n_bad++; $display("FAIL copy_busy_low: got cycle %0d, required 10", ic); end
    n_cmp++; if (rd !== 4 || wr !== 4) begin n_bad++; $display("FAIL copy_accesses: rd=%0d wr=%0d, required 4/4", rd, wr); end
    n_cmp++; if (count !== 16'd4) begin n_bad++; $display("FAIL copy_count: got %0d, required 4", count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0080 + 16'(i)] !== 8'h11 * 8'(i + 1)) begin
        n_bad++;
        $display("FAIL copy_data[%0d]: got %h, required %h", i, mem[16'h0080 + 16'(i)], 8'h11 * 8'(i + 1));
      end
    end
  endtask

  task automatic test_fill();
    int dc, dp, rd, wr, ic;
    run_cmd(1'b1, 16'h0000, 16'h0200, 16'd3, 8'hA5, 0, dc, dp, rd, wr, ic);
    n_cmp++; if (dc !== 4) begin n_bad++; $display("FAIL fill_done_cycle: got %0d, required 4", dc); end
    n_cmp++; if (ic !== 5) begin n_bad++; $display("FAIL fill_busy_low: got cycle %0d, required 5", ic); end
    n_cmp++; if (rd !== 0 || wr !== 3) begin n_bad++; $display("FAIL fill_accesses: rd=%0d wr=%0d, required 0/3", rd, wr); end
    n_cmp++; if (count !== 16'd3) begin n_bad++; $display("FAIL fill_count: got %0d, required 3", count); end
    for (int i = 0; i < wa_q.size() && i < 3; i++) begin
      n_cmp++;
      if (wa_q[i] !== 16'h0200 + 16'(i) || wd_q[i] !== 8'hA5) begin
        n_bad++;
        $display("FAIL fill_write[%0d]: got %h<=%h, required %h<=a5", i, wa_q[i], wd_q[i], 16'h0200 + 16'(i));
      end
    end
  endtask

  task automatic test_zero_len();
    int dc, dp, rd, wr, ic;
    run_cmd(1'b0, 16'h0010, 16'h0080, 16'd0, 8'h00, 0, dc, dp, rd, wr, ic);
    n_cmp++; if (dc !== 1 || dp !== 1) begin n_bad++; $display("FAIL zero_done: cycle %0d pulses %0d, required 1/1", dc, dp); end
    n_cmp++; if (ic !== 2) begin n_bad++; $display("FAIL zero_busy_low: got cycle %0d, required 2", ic); end
    n_cmp++; if (rd !== 0 || wr !== 0) begin n_bad++; $display("FAIL zero_accesses: rd=%0d wr=%0d, required 0/0", rd, wr); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL zero_count: got %0d, required 0", count); end
  endtask

  task automatic test_busy_ignore();
    int dc, dp, rd, wr, ic;
    // A second start lands mid-copy (cycle 3) and then in the DONE cycle (cycle 9).
    for (int k = 0; k < 2; k++) begin
      run_cmd(1'b0, 16'h0010, 16'h0090, 16'd4, 8'h00, (k == 0) ? 3 : 9, dc, dp, rd, wr, ic);
      n_cmp++; if (dc !== 9 || ic !== 10) begin n_bad++; $display("FAIL ignore_timing[%0d]: done %0d idle %0d, required 9/10", k, dc, ic); end
      n_cmp++; if (rd !== 4 || wr !== 4) begin n_bad++; $display("FAIL ignore_accesses[%0d]: rd=%0d wr=%0d, required 4/4", k, rd, wr); end
      n_cmp++; if (count !== 16'd4) begin n_bad++; $display("FAIL ignore_count[%0d]: got %0d, required 4", k, count); end
      n_cmp++; if (mem[16'h0300] !== 8'h00) begin n_bad++; $display("FAIL ignore_side_effect[%0d]: mem[300]=%h, required 00", k, mem[16'h0300]); end
      n_cmp++; if (mem[16'h0093] !== 8'h44) begin n_bad++; $display("FAIL ignore_data[%0d]: mem[93]=%h, required 44", k, mem[16'h0093]); end
    end
  endtask

  task automatic test_wrap_fill();
    int dc, dp, rd, wr, ic;
    logic [15:0] ea;
    run_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h5A, 0, dc, dp, rd, wr, ic);
    n_cmp++; if (dc !== 5 || wr !== 4) begin n_bad++; $display("FAIL wrap_done: cycle %0d writes %0d, required 5/4", dc, wr); end
    for (int i = 0; i < wa_q.size() && i < 4; i++) begin
      ea = 16'hFFFE + 16'(i);
      n_cmp++;
      if (wa_q[i] !== ea || wd_q[i] !== 8'h5A) begin
        n_bad++;
        $display("FAIL wrap_write[%0d]: got %h<=%h, required %h<=5a", i, wa_q[i], wd_q[i], ea);
      end
    end
    n_cmp++; if (mem[16'h0001] !== 8'h5A) begin n_bad++; $display("FAIL wrap_mem1: got %h, required 5a", mem[16'h0001]); end
  endtask

  task automatic test_overlap();
    int dc, dp, rd, wr, ic;
    run_cmd(1'b0, 16'h0040, 16'h0041, 16'd3, 8'h00, 0, dc, dp, rd, wr, ic);
    n_cmp++; if (dc !== 7 || count !== 16'd3) begin n_bad++; $display("FAIL overlap_done: cycle %0d count %0d, required 7/3", dc, count); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0040 + 16'(i)] !== 8'h07) begin
        n_bad++;
        $display("FAIL overlap_data[%0d]: got %h, required 07", i, mem[16'h0040 + 16'(i)]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc, dp, rd, wr, ic;
    start = 1'b1; mode = 1'b0; src = 16'h0050; dst = 16'h00A0; len = 16'd8; fill_byte = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b1 || mem_addr !== 16'h00A2) begin
      n_bad++;
      $display("FAIL rmid_third_write: wr=%b addr=%h, required 1/00a2", mem_write, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, count, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL rmid_outputs: busy=%b done=%b count=%h rd=%b wr=%b addr=%h wdata=%h, required all 0",
               busy, done, count, mem_read, mem_write, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++;
    if (mem[16'h00A0] !== 8'h61 || mem[16'h00A1] !== 8'h62 || mem[16'h00A2] !== 8'hEE) begin
      n_bad++;
      $display("FAIL rmid_mem: a0..a2=%h %h %h, required 61 62 ee", mem[16'h00A0], mem[16'h00A1], mem[16'h00A2]);
    end
    @(negedge clk);
    run_cmd(1'b1, 16'h0000, 16'h00A2, 16'd1, 8'h77, 0, dc, dp, rd, wr, ic);
    n_cmp++;
    if (dc !== 2 || count !== 16'd1 || mem[16'h00A2] !== 8'h77) begin
      n_bad++;
      $display("FAIL rmid_restart: done %0d count %0d mem[a2]=%h, required 2/1/77", dc, count, mem[16'h00A2]);
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_zero_len();
    test_busy_ignore();
    test_wrap_fill();
    test_overlap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Byte-wide block-transfer engine that drives the single-port memory interface (read, write, addr, write_byte, read_byte) as its initiator. On a start command it either copies a range of bytes from a source address to a destination address, or fills a destination range with a constant byte. It sits between the loader/control logic and the shared memory, so that bulk moves never need a CPU loop.

## Interface
- addr_width, 16, width of all address and length fields; addresses wrap modulo 2^addr_width.
- clk  in  1  system clock, all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only while busy=0.
- mode  in  1  0 = copy, 1 = fill; latched with start.
- src  in  addr_width  copy source start address; latched with start; ignored in fill mode.
- dst  in  addr_width  destination start address; latched with start.
- len  in  addr_width  byte count; latched with start; 0 = no transfer.
- fill_byte  in  8  fill value; latched with start.
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle completion pulse.
- count  out  addr_width  bytes written so far in the current or last command.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  addr_width  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; combinationally valid while mem_read=1.

## Operation
- States: IDLE, READ, WRITE, DONE. All memory outputs decode from registered state/pointers only (Moore).
- IDLE: all outputs 0 except count (holds last value). On start=1: latch fields, count<=0, src_ptr<=src, dst_ptr<=dst, rem<=len, then:
  - len=0 -> DONE.
  - mode=0 -> READ.
  - mode=1 -> WRITE with data<=fill_byte.
- READ: mem_read=1, mem_addr=src_ptr. At the edge: data<=mem_rdata, src_ptr++, then go to WRITE.
- WRITE: mem_write=1, mem_addr=dst_ptr, mem_wdata=data. At the edge: dst_ptr++, count++, rem--. Then:
  - rem was 1 -> DONE.
  - otherwise, copy -> READ and fill -> WRITE.
- DONE: done=1, busy=1, memory enables 0; next state is IDLE.
- mem_read and mem_write are never high in the same cycle. mem_addr=0 and mem_wdata=0 when neither is high.
- Transfer order is strictly ascending. Overlapping copies with dst in (src, src+len) are defined byte-by-byte: each read sees earlier writes, which gives a pattern-replication effect.
- Pointer arithmetic is addr_width-bit unsigned, so 0xFFFF+1 = 0x0000. rem is never checked against memory size.
- start while busy=1 is ignored with no side effect. Field changes after acceptance have no effect.
- reset_n low at any time: state goes to IDLE immediately (asynchronously). busy, done, count, mem_read and mem_write go to 0, and pointers/data clear. A write in progress is dropped, because mem_write falls before the next edge.

## Timing
- Start accepted at edge E0; busy=1 from E0 to the edge ending DONE.
- Copy of N bytes: READ/WRITE pairs occupy cycles 1..2N after E0. DONE is cycle 2N+1, IDLE is cycle 2N+2.
- Fill of N bytes: WRITE occupies cycles 1..N. DONE is cycle N+1.
- len=0: DONE is cycle 1; no memory access.
- Read-data latency: 0 cycles (mem_rdata captured at the end of the READ cycle).
- Memory write commits at the end of each WRITE cycle.
- The earliest next start is accepted in the first IDLE cycle after DONE.
- Throughput: copy is 1 byte per 2 cycles; fill is 1 byte per cycle.

## Test plan
- Copy: mem[0x10..0x13]=11,22,33,44; start mode=0 src=0x10 dst=0x80 len=4 -> mem[0x80..0x83]=11,22,33,44. done pulses in cycle 9 only; count=4; busy low from cycle 10.
- Fill: mode=1 dst=0x200 len=3 fill_byte=0xA5 -> three consecutive writes of A5 to 0x200..0x202, done in cycle 4, mem_read never asserted.
- Zero length and ignore: len=0 -> done in cycle 1 with no read/write. A second start asserted during any busy copy causes no extra access and no change to count.
- Wrap and overlap: fill dst=0xFFFE len=4 0x5A -> writes at FFFE, FFFF, 0000, 0001. Copy src=0x40 dst=0x41 len=3 with mem[0x40]=7 -> mem[0x41..0x43]=7,7,7.
- Reset mid-transfer: reset_n low during the 3rd WRITE of a len=8 copy -> mem_write drops the same cycle and that byte is not stored. All outputs are 0 and count=0. After release, a new start works normally.
- Protocol check across all tests: mem_read and mem_write are never both 1; mem_addr and mem_wdata are 0 when idle.
